// File: rtl/jk_sched_pkg.sv
// Shared definitions for the JK bank scheduler: command encoding, FSM states and the
// expected-readback rule.
package jk_sched_pkg;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_e;

    // Value a JK flop must hold after one clock of the given {J,K} command.
    function automatic logic expected_bit(input logic [1:0] op, input logic q);
        logic r;
        case (op)
            OP_HOLD:  r = q;
            OP_RESET: r = 1'b0;
            OP_SET:   r = 1'b1;
            default:  r = ~q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the priority pointer only moves when the grant is
// actually consumed (en_i).
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
        ptr_d = ptr_q;
        // After granting A the pointer favours B, and vice versa.
        if (en_i && (gnt_o != 2'b00)) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/jk_bank_scheduler.sv
// Arbitrates per-bit JK commands from two requesters, drives the bank for one clock,
// waits a settle interval and reports completion with a readback-mismatch flag.
module jk_bank_scheduler #(
    parameter int WIDTH      = 8,
    parameter int IDX_W      = $clog2(WIDTH),
    parameter int SETTLE_CYC = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VALID_A,
    input  logic             VALID_B,
    output logic             READY_A,
    output logic             READY_B,
    input  logic [1:0]       OP_A,
    input  logic [1:0]       OP_B,
    input  logic [IDX_W-1:0] IDX_A,
    input  logic [IDX_W-1:0] IDX_B,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] Q,
    output logic             DONE,
    output logic             ERR,
    output logic             GNT_ID
);

    import jk_sched_pkg::*;

    localparam logic [IDX_W:0] WIDTH_L  = (IDX_W + 1)'(WIDTH);
    localparam logic [3:0]     CNT_LAST = 4'(SETTLE_CYC - 1);

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               gnt_id_q, gnt_id_d;
    logic               exp_q, exp_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   j_q, j_d, k_q, k_d;

    logic [1:0]         gnt;
    logic               idle;
    logic               hs;
    logic [1:0]         sel_op;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_inr;
    logic               sel_qbit;
    logic [WIDTH-1:0]   sel_hot;
    logic               idx_inr;
    logic               rb_qbit;

    // Gating with RST keeps READY low while reset is held, even though the state is IDLE.
    assign idle    = (state_q == ST_IDLE) && !RST;
    assign READY_A = idle && gnt[0];
    assign READY_B = idle && gnt[1];
    assign hs      = idle && (gnt != 2'b00);

    rr_arb2 u_arb (
        .clk_i (CLK),
        .rst_i (RST),
        .req_i ({VALID_B, VALID_A}),
        .en_i  (hs),
        .gnt_o (gnt)
    );

    assign sel_op   = gnt[1] ? OP_B : OP_A;
    assign sel_idx  = gnt[1] ? IDX_B : IDX_A;
    assign sel_inr  = {1'b0, sel_idx} < WIDTH_L;
    assign sel_qbit = sel_inr ? Q[sel_idx] : 1'b0;
    assign sel_hot  = sel_inr ? ({{(WIDTH-1){1'b0}}, 1'b1} << sel_idx) : '0;
    assign idx_inr  = {1'b0, idx_q} < WIDTH_L;
    assign rb_qbit  = idx_inr ? Q[idx_q] : 1'b0;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        idx_d    = idx_q;
        gnt_id_d = gnt_id_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = err_q;
        j_d      = '0;
        k_d      = '0;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    op_d     = sel_op;
                    idx_d    = sel_idx;
                    gnt_id_d = gnt[1];
                    exp_d    = expected_bit(sel_op, sel_qbit);
                    // J/K are registered so they appear exactly in the DRIVE cycle.
                    j_d      = sel_op[1] ? sel_hot : '0;
                    k_d      = sel_op[0] ? sel_hot : '0;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    err_d   = !idx_inr || (rb_qbit != exp_q);
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_HOLD;
            idx_q    <= '0;
            gnt_id_q <= 1'b0;
            exp_q    <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            j_q      <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            gnt_id_q <= gnt_id_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            j_q      <= j_d;
            k_q      <= k_d;
        end
    end

    assign J      = j_q;
    assign K      = k_q;
    assign DONE   = done_q;
    assign ERR    = err_q;
    assign GNT_ID = gnt_id_q;

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Bench for jk_bank_scheduler: a transaction-level model predicts grants, J/K pulses and
// completions; a negedge monitor compares the DUT against the scoreboard queue.
module tb_jk_bank_scheduler;

    localparam int W  = 6;
    localparam int IW = 3;
    localparam int S  = 1;

    localparam logic [1:0] C_HOLD = 2'b00;
    localparam logic [1:0] C_RST  = 2'b01;
    localparam logic [1:0] C_SET  = 2'b10;
    localparam logic [1:0] C_TOG  = 2'b11;

    logic          CLK, RST;
    logic          VALID_A, VALID_B, READY_A, READY_B;
    logic [1:0]    OP_A, OP_B;
    logic [IW-1:0] IDX_A, IDX_B;
    logic [W-1:0]  J, K, Q;
    logic          DONE, ERR, GNT_ID;

    jk_bank_scheduler #(
        .WIDTH      (W),
        .IDX_W      (IW),
        .SETTLE_CYC (S)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .VALID_A (VALID_A),
        .VALID_B (VALID_B),
        .READY_A (READY_A),
        .READY_B (READY_B),
        .OP_A    (OP_A),
        .OP_B    (OP_B),
        .IDX_A   (IDX_A),
        .IDX_B   (IDX_B),
        .J       (J),
        .K       (K),
        .Q       (Q),
        .DONE    (DONE),
        .ERR     (ERR),
        .GNT_ID  (GNT_ID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural JK bank; bank_ignore models a broken bank that never changes state.
    logic [W-1:0] bank_q = '0;
    bit           bank_ignore = 1'b0;
    always @(posedge CLK) begin
        if (!RST && !bank_ignore) begin
            for (int i = 0; i < W; i++) begin
                case ({J[i], K[i]})
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end
    assign Q = bank_q;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct {
        int done_c;
        bit id;
        bit err;
        int idx;
        bit inr;
        bit val;
    } exp_t;

    exp_t         sb[$];
    bit           ptr_m = 1'b0;
    int           next_free = 0;
    bit           ref_bits[W];
    logic         last_err = 1'b0;
    int           drive_c = -1;
    logic [W-1:0] drive_j, drive_k;

    always @(negedge CLK) begin : mon
        int         c;
        bit         ea, eb, side, inr, old, req, newv;
        logic [1:0] op;
        int         idx;
        exp_t       e;
        c = cyc;
        if (RST) begin
            check("reset_outputs", {J, K, READY_A, READY_B, DONE, ERR, GNT_ID}, '0);
            sb.delete();
            ptr_m = 1'b0;
            next_free = 0;
            last_err = 1'b0;
            drive_c = -1;
            for (int i = 0; i < W; i++) ref_bits[i] = bank_q[i];
        end else begin
            if (c == drive_c) check("jk_drive", {J, K}, {drive_j, drive_k});
            else              check("jk_quiet", {J, K}, '0);

            if (sb.size() > 0 && sb[0].done_c == c) begin
                e = sb.pop_front();
                check("done_pulse", DONE, 1);
                check("gnt_id", GNT_ID, e.id);
                check("err_flag", ERR, e.err);
                if (e.inr) check("q_readback", bank_q[e.idx], e.val);
                last_err = e.err;
            end else begin
                check("no_done", DONE, 0);
                check("err_hold", ERR, last_err);
            end

            if (c >= next_free) begin
                ea = VALID_A && (!VALID_B || !ptr_m);
                eb = VALID_B && (!VALID_A || ptr_m);
                check("ready_idle", {READY_A, READY_B}, {ea, eb});
                if (ea || eb) begin
                    side = eb;
                    op   = eb ? OP_B : OP_A;
                    idx  = eb ? int'(IDX_B) : int'(IDX_A);
                    inr  = idx < W;
                    old  = inr ? ref_bits[idx] : 1'b0;
                    case (op)
                        C_HOLD:  req = old;
                        C_RST:   req = 1'b0;
                        C_SET:   req = 1'b1;
                        default: req = !old;
                    endcase
                    newv = (inr && !bank_ignore) ? req : old;
                    if (inr) ref_bits[idx] = newv;
                    drive_c = c + 1;
                    drive_j = '0;
                    drive_k = '0;
                    if (inr) begin
                        drive_j[idx] = op[1];
                        drive_k[idx] = op[0];
                    end
                    e.done_c = c + 2 + S;
                    e.id     = side;
                    e.err    = !inr || (newv != req);
                    e.idx    = idx;
                    e.inr    = inr;
                    e.val    = newv;
                    sb.push_back(e);
                    ptr_m     = !side;
                    next_free = c + 3 + S;
                end
            end else begin
                check("ready_busy", {READY_A, READY_B}, 2'b00);
            end
        end
    end

    // Present a command and wait for its handshake; VALID stays high afterwards.
    task automatic send(input bit side, input logic [1:0] op, input logic [IW-1:0] idx);
        bit ok = 1'b0;
        @(posedge CLK); #1;
        if (side) begin VALID_B = 1'b1; OP_B = op; IDX_B = idx; end
        else      begin VALID_A = 1'b1; OP_A = op; IDX_A = idx; end
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge CLK);
            ok = side ? (VALID_B && READY_B) : (VALID_A && READY_A);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake_timeout: side %0d got no grant, required one", side);
        end
    endtask

    task automatic drop(input bit side);
        @(posedge CLK); #1;
        if (side) VALID_B = 1'b0;
        else      VALID_A = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge CLK);
        @(negedge CLK);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d pending, required 0", sb.size());
        end
    endtask

    task automatic rand_side(input bit side, input int n);
        int gap;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                drop(side);
                repeat (gap) @(posedge CLK);
            end
            send(side, 2'($urandom_range(0, 3)), IW'($urandom_range(0, 7)));
        end
        drop(side);
    endtask

    initial begin
        RST = 1'b1;
        VALID_A = 1'b0; VALID_B = 1'b0;
        OP_A = C_HOLD;  OP_B = C_HOLD;
        IDX_A = '0;     IDX_B = '0;
        #50;
        @(posedge CLK); #1 RST = 1'b0;

        send(0, C_SET, 3); drop(0); drain();

        send(0, C_RST, 3); send(0, C_TOG, 3); send(0, C_TOG, 3); drop(0); drain();

        fork
            begin for (int k = 0; k < 8; k++) send(0, C_TOG, IW'(k % W)); drop(0); end
            begin for (int k = 0; k < 8; k++) send(1, C_SET, IW'((k + 2) % W)); drop(1); end
        join
        drain();

        send(1, C_RST, 0); drop(1); drain();
        bank_ignore = 1'b1;
        send(1, C_SET, 0); drop(1); drain();
        check("ignored_bank_err", ERR, 1);
        bank_ignore = 1'b0;

        send(0, C_SET, 7); drop(0); drain();
        check("out_of_range_err", ERR, 1);
        send(0, C_HOLD, 1); drop(0); drain();
        check("in_range_err_clear", ERR, 0);

        fork
            rand_side(0, 30);
            rand_side(1, 30);
        join
        drain();

        // Reset during SETTLE of a TOGGLE issued by A: pointer must come back to A.
        send(0, C_TOG, 2);
        @(posedge CLK);
        @(posedge CLK); #2 RST = 1'b1;
        #1 check("settle_reset_jk", {J, K}, '0);
        @(posedge CLK);
        @(posedge CLK); #1 RST = 1'b0;
        VALID_B = 1'b1; OP_B = C_SET; IDX_B = 3'd4;
        @(negedge CLK);
        check("ptr_back_to_a", {READY_A, READY_B}, 2'b10);
        drop(0); drop(1); drain();

        // Reset asserted inside the DRIVE cycle must clear J/K without waiting for a clock.
        send(0, C_SET, 5);
        @(posedge CLK); #1;
        check("drive_before_reset", {J, K}, {6'b100000, 6'b000000});
        #1 RST = 1'b1;
        #1 check("async_jk_clear", {J, K}, '0);
        @(posedge CLK); #1 RST = 1'b0;
        drop(0); drain();

        send(1, C_TOG, 1); drop(1); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/jk_bank_scheduler.md
# jk_bank_scheduler

Arbitrating command sequencer for a bank of master-slave JK flip-flops. Two requesters (A, B) issue per-bit HOLD/RESET/SET/TOGGLE commands. The block grants one command at a time with round-robin priority and drives the bank's J/K inputs for exactly one clock. It then waits a settle interval, reads Q back, and reports completion with a mismatch flag. It sits between software- or FSM-level requesters and the JK register bank, which it owns exclusively.

## Interface
- WIDTH, 8: number of JK flip-flops in the bank (2..64).
- IDX_W, $clog2(WIDTH): width of bit-index fields.
- SETTLE_CYC, 1: cycles between the J/K drive cycle and Q readback (1..15).

- CLK  in  1  single clock; all state on rising edge.
- RST  in  1  reset; one clock, reset is asynchronous and active-high.
- VALID_A / VALID_B  in  1  requester command valid.
- READY_A / READY_B  out  1  requester command accepted when VALID&&READY.
- OP_A / OP_B  in  2  command, encoded as {J,K}: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- IDX_A / IDX_B  in  IDX_W  target bit.
- J  out  WIDTH  J inputs to bank.
- K  out  WIDTH  K inputs to bank.
- Q  in  WIDTH  bank outputs.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  valid with DONE: readback mismatch or index out of range.
- GNT_ID  out  1  requester of the current/last command (0=A, 1=B).

## Operation
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
- IDLE:
  - READY_x = (state==IDLE) && grant_x, where grant comes from a 2-way round-robin arbiter on VALID_A/VALID_B.
  - On handshake, latch op, idx and GNT_ID; compute expected value. SET→1, RESET→0, HOLD→Q[idx], TOGGLE→~Q[idx], with Q sampled on the handshake cycle.
  - Go to DRIVE.
- DRIVE: J[idx]=op[1], K[idx]=op[0]; all other J/K bits 0. Exactly one cycle, then SETTLE.
- SETTLE: J=K=0; count SETTLE_CYC cycles, then CHECK.
- CHECK:
  - DONE=1 for one cycle.
  - ERR=1 if Q[idx] != expected, or idx >= WIDTH.
  - Return to IDLE.
- Out-of-range idx: the command is accepted and J/K stay all-zero in DRIVE. Sequence and latency are unchanged; ERR=1.
- Arbitration:
  - Both valid: the priority pointer picks; after the grant, the pointer moves to the other requester.
  - Only one valid: that requester is granted regardless of the pointer; the pointer then points to the other.
  - The pointer resets to A.
- Requests are never accepted outside IDLE; READY_A and READY_B are never both 1.

## Timing
- Reset values:
  - J=0, K=0, DONE=0, ERR=0, GNT_ID=0, READY_A/B=0.
  - State IDLE, pointer=A, settle counter 0.
- RST asserted mid-operation clears J/K immediately (async); the in-flight command is dropped, with no DONE.
- Handshake on cycle n:
  - DRIVE on n+1.
  - SETTLE on n+2 .. n+1+SETTLE_CYC.
  - DONE on n+2+SETTLE_CYC.
- Earliest next handshake is the cycle after DONE. Back-to-back throughput is one command per 3+SETTLE_CYC cycles.
- DONE and ERR are registered outputs; ERR holds its value until the next DONE.
- Exactly one J/K bit pair can be non-zero, and only in DRIVE.

## Structure
- Package jk_sched_pkg:
  - op encoding localparams (OP_HOLD, OP_RESET, OP_SET, OP_TOGGLE);
  - state enum typedef;
  - expected-value function.
- Sub-module rr_arb2: 2-requester round-robin arbiter with enable (advance only on handshake). Outputs are one-hot grant plus a pointer register.
- Top instantiates rr_arb2, the FSM, the settle counter and the J/K decode.

## Test plan
- Reset: hold RST for 50 ns, release; then A issues SET idx 3. Required:
  - all outputs 0 during reset;
  - J[3]=1, K=0 for one cycle;
  - DONE 3 cycles after the handshake (SETTLE_CYC=1), with ERR=0 and Q[3]=1.
- A issues RESET idx 3, then TOGGLE idx 3 twice. Required: Q[3] goes 0→1→0; every DONE has ERR=0; J[3]=K[3]=1 only in the DRIVE cycles.
- VALID_A and VALID_B held high continuously. Required:
  - grants alternate A, B, A, B, with GNT_ID following;
  - never both READY;
  - one command per 4 cycles.
- Bank model forced to ignore J/K; B issues SET idx 0 with Q[0]=0. Required: DONE with ERR=1.
- With WIDTH=6, A issues SET idx 7. Required: J=K=0 throughout; DONE at normal latency with ERR=1.
- RST asserted during SETTLE of a TOGGLE. Required: J/K drop to 0 asynchronously, no DONE, and the pointer returns to A; the next command completes normally.
